pack_number: RTL and testbench

Sequential packer that rebuilds an IEEE-754 single-precision word from the unpacked fields produced by the operand-unpacking front end and consumed by the arithmetic datapath: sign, biased exponent, 28-bit extended mantissa and 3-bit type code. It sits at the output of the add/mul units and performs normalization (one bit per cycle), round-to-nearest-even, overflow/underflow handling and final packing. Valid/ready handshakes are used on both sides; one operation is in flight at a time.

---
 rtl/pack_number.sv | 177 +++++++++++++++++
 tb/tb_pack_number.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pack_number.sv
// pack_number: rebuilds an IEEE-754 single-precision word from unpacked fields
// (sign, biased exponent, 28-bit extended mantissa, type code). Normalizes one
// bit per cycle, rounds to nearest even, then packs.
// Gradual underflow is built only when PACK_NUMBER_DENORM_EN is defined;
// otherwise tiny results flush to signed zero.
// The spec's "type" port is named type_code because "type" is a reserved word.
module pack_number (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign,
  input  logic [9:0]  exp,
  input  logic [27:0] ext_mantis,
  input  logic [2:0]  type_code,
  output logic [31:0] number,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_inexact,
  output logic        out_overflow
);

  typedef enum logic [1:0] {StIdle, StNorm, StRound, StOut} state_e;

  state_e             state_q;
  logic               sign_q;
  // One bit wider than the input so the +1 steps in NORM/ROUND cannot wrap
  logic signed [10:0] exp_q;
  logic [27:0]        mant_q;
  logic [31:0]        number_q;
  logic               out_valid_q;
  logic               inexact_q;
  logic               overflow_q;
`ifndef PACK_NUMBER_DENORM_EN
  logic               tiny_q;
`endif

  logic               is_special;
  logic [31:0]        spec_word;
  logic               rnd_inc;
  logic [24:0]        rnd_sum;
  logic [23:0]        rnd_m;
  logic signed [10:0] rnd_exp;
  logic [31:0]        rnd_word;
  logic               rnd_ovf;
  logic               rnd_inexact;

  assign in_ready     = (state_q == StIdle);
  assign number       = number_q;
  assign out_valid    = out_valid_q;
  assign out_inexact  = inexact_q;
  assign out_overflow = overflow_q;

  // Pack zero / infinity / NaN straight from the input fields
  always_comb begin
    is_special = 1'b1;
    spec_word  = {sign, 31'b0};
    case (type_code)
      3'd0:    spec_word = {sign, 31'b0};
      3'd3:    spec_word = {sign, 8'hFF, 23'b0};
      3'd4:    spec_word = {sign, 8'hFF, 1'b1, ext_mantis[24:3]};
      default: is_special = 1'b0;
    endcase
  end

  // Round-to-nearest-even on the normalized mantissa, then pack
  always_comb begin
    rnd_inc     = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
    rnd_sum     = {1'b0, mant_q[26:3]} + {24'b0, rnd_inc};
    rnd_inexact = |mant_q[2:0];
    rnd_ovf     = 1'b0;
    if (rnd_sum[24]) begin
      rnd_m   = rnd_sum[24:1];
      rnd_exp = exp_q + 11'sd1;
    end else begin
      rnd_m   = rnd_sum[23:0];
      rnd_exp = exp_q;
    end
    if (rnd_exp >= 11'sd255) begin
      rnd_word = {sign_q, 8'hFF, 23'b0};
      rnd_ovf  = 1'b1;
    end else if (rnd_m[23]) begin
      rnd_word = {sign_q, rnd_exp[7:0], rnd_m[22:0]};
    end else begin
      rnd_word = {sign_q, 8'h00, rnd_m[22:0]};
    end
`ifndef PACK_NUMBER_DENORM_EN
    // Flush-to-zero: any subnormal outcome becomes signed zero
    if (tiny_q || !rnd_m[23]) begin
      rnd_word    = {sign_q, 31'b0};
      rnd_ovf     = 1'b0;
      rnd_inexact = 1'b1;
    end
`endif
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
      number_q    <= '0;
      out_valid_q <= 1'b0;
      inexact_q   <= 1'b0;
      overflow_q  <= 1'b0;
`ifndef PACK_NUMBER_DENORM_EN
      tiny_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            sign_q     <= sign;
            exp_q      <= {exp[9], exp};
            mant_q     <= ext_mantis;
            inexact_q  <= 1'b0;
            overflow_q <= 1'b0;
`ifndef PACK_NUMBER_DENORM_EN
            tiny_q     <= ($signed(exp) < 10'sd1);
`endif
            if (is_special) begin
              // out_valid follows one cycle later, from StOut
              number_q <= spec_word;
              state_q  <= StOut;
            end else begin
              state_q  <= StNorm;
            end
          end
        end
        StNorm: begin
          if (mant_q == 28'd0) begin
            number_q    <= {sign_q, 31'b0};
            out_valid_q <= 1'b1;
            state_q     <= StOut;
`ifdef PACK_NUMBER_DENORM_EN
          end else if (exp_q < -11'sd26) begin
            mant_q <= {27'b0, |mant_q};
            exp_q  <= 11'sd1;
`endif
          end else if (mant_q[27]) begin
            mant_q <= {1'b0, mant_q[27:2], mant_q[1] | mant_q[0]};
            exp_q  <= exp_q + 11'sd1;
`ifdef PACK_NUMBER_DENORM_EN
          end else if (exp_q < 11'sd1) begin
            mant_q <= {1'b0, mant_q[27:2], mant_q[1] | mant_q[0]};
            exp_q  <= exp_q + 11'sd1;
`endif
          end else if (!mant_q[26] && (exp_q > 11'sd1)) begin
            mant_q <= {mant_q[26:0], 1'b0};
            exp_q  <= exp_q - 11'sd1;
          end else begin
            state_q <= StRound;
          end
        end
        StRound: begin
          number_q    <= rnd_word;
          inexact_q   <= rnd_inexact;
          overflow_q  <= rnd_ovf;
          out_valid_q <= 1'b1;
          state_q     <= StOut;
        end
        StOut: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pack_number.sv
// Directed, table-driven bench for pack_number. Expected values follow the
// PACK_NUMBER_DENORM_EN setting of the build.
module tb_pack_number;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sign = 1'b0;
  logic [9:0]  exp = '0;
  logic [27:0] ext_mantis = '0;
  logic [2:0]  type_code = '0;
  logic [31:0] number;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_inexact;
  logic        out_overflow;

  int tests = 0;
  int fails = 0;

  pack_number dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .sign         (sign),
    .exp          (exp),
    .ext_mantis   (ext_mantis),
    .type_code    (type_code),
    .number       (number),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_inexact  (out_inexact),
    .out_overflow (out_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        s;
    logic [9:0]  e;
    logic [27:0] m;
    logic [2:0]  t;
    logic [31:0] num;
    int          lat;
    logic        inx;
    logic        ovf;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // Present one operation; returns after the accept edge with inputs scrambled
  task automatic drive(input logic s, input logic [9:0] e, input logic [27:0] m,
                       input logic [2:0] t);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
    sign = s; exp = e; ext_mantis = m; type_code = t; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sign = 1'($urandom); exp = 10'($urandom); ext_mantis = 28'($urandom);
    type_code = 3'($urandom_range(0, 4));
  endtask

  // Count edges after the accept edge until out_valid is seen
  task automatic wait_out(output int n);
    n = 0;
    while (n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) break;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    drive(v.s, v.e, v.m, v.t);
    wait_out(n);
    check({v.name, "_out_valid"}, {31'b0, out_valid}, 32'd1);
    check({v.name, "_latency"}, n, v.lat);
    check({v.name, "_number"}, number, v.num);
    check({v.name, "_inexact"}, {31'b0, out_inexact}, {31'b0, v.inx});
    check({v.name, "_overflow"}, {31'b0, out_overflow}, {31'b0, v.ovf});
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    vecs[0]  = '{"one", 1'b0, 10'd127, 28'h4000000, 3'd2, 32'h3F800000, 2, 1'b0, 1'b0};
    vecs[1]  = '{"lshift3", 1'b0, 10'd130, 28'h0800000, 3'd2, 32'h3F800000, 5, 1'b0, 1'b0};
    vecs[2]  = '{"rne_tie_even", 1'b0, 10'd127, 28'h4000004, 3'd2, 32'h3F800000, 2, 1'b1, 1'b0};
    vecs[3]  = '{"rne_tie_odd", 1'b0, 10'd127, 28'h400000C, 3'd2, 32'h3F800002, 2, 1'b1, 1'b0};
    vecs[4]  = '{"carry_in", 1'b0, 10'd127, 28'h8000000, 3'd2, 32'h40000000, 3, 1'b0, 1'b0};
    vecs[5]  = '{"round_ovf", 1'b0, 10'd254, 28'h7FFFFFC, 3'd2, 32'h7F800000, 2, 1'b1, 1'b1};
    vecs[6]  = '{"nan", 1'b0, 10'd0, 28'h0000008, 3'd4, 32'h7FC00001, 1, 1'b0, 1'b0};
    vecs[7]  = '{"neg_inf", 1'b1, 10'd5, 28'h0000000, 3'd3, 32'hFF800000, 1, 1'b0, 1'b0};
    vecs[8]  = '{"neg_zero", 1'b1, 10'd77, 28'h1234560, 3'd0, 32'h80000000, 1, 1'b0, 1'b0};
    vecs[9]  = '{"zero_mant", 1'b0, 10'd100, 28'h0000000, 3'd2, 32'h00000000, 1, 1'b0, 1'b0};
    vecs[10] = '{"neg_three", 1'b1, 10'd128, 28'h6000000, 3'd2, 32'hC0400000, 2, 1'b0, 1'b0};
    vecs[11] = '{"exp255", 1'b0, 10'd255, 28'h4000000, 3'd2, 32'h7F800000, 2, 1'b0, 1'b1};
`ifdef PACK_NUMBER_DENORM_EN
    vecs[12] = '{"denorm_exp0", 1'b1, 10'd0, 28'h4000000, 3'd1, 32'h80400000, 3, 1'b0, 1'b0};
    vecs[13] = '{"collapse", 1'b0, 10'h3E2, 28'h4000000, 3'd1, 32'h00000000, 3, 1'b1, 1'b0};
    vecs[14] = '{"denorm_exp1", 1'b0, 10'd1, 28'h2000000, 3'd1, 32'h00400000, 2, 1'b0, 1'b0};
`else
    vecs[12] = '{"ftz_exp0", 1'b1, 10'd0, 28'h4000000, 3'd1, 32'h80000000, 2, 1'b1, 1'b0};
    vecs[13] = '{"ftz_very_tiny", 1'b0, 10'h3E2, 28'h4000000, 3'd1, 32'h00000000, 2, 1'b1, 1'b0};
    vecs[14] = '{"ftz_exp1", 1'b0, 10'd1, 28'h2000000, 3'd1, 32'h00000000, 2, 1'b1, 1'b0};
`endif

    // Reset state
    #12;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_number", number, 32'd0);
    check("rst_flags", {30'b0, out_inexact, out_overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) run_vec(vecs[i]);

    // Backpressure: output held stable while out_ready is low
    drive(1'b0, 10'd0, 28'h0000008, 3'd4);
    wait_out(n);
    check("hold_latency", n, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_number", number, 32'h7FC00001);
      check("hold_out_valid", {31'b0, out_valid}, 32'd1);
      check("hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("after_xfer_in_ready", {31'b0, in_ready}, 32'd1);
    check("after_xfer_out_valid", {31'b0, out_valid}, 32'd0);

    // Asynchronous reset in the middle of normalization
    drive(1'b0, 10'd130, 28'h0800000, 3'd2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    check("midrst_number", number, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Recovery after the aborted operation
    run_vec(vecs[3]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want finish");
    $fatal(1, "timeout");
  end

endmodule
